// File: rtl/sm4_key_expand.sv
// sm4_key_expand: iterative SM4 key schedule producing rk0..rk31, one round key per clock.
// Ports: clk/rst_n (async active-low reset); key_valid/key_ready/mkey master-key handshake
// (MK0 is the most significant word of mkey); ck_num/ck_in combinational CK constant lookup;
// rk_valid/rk_idx/rk/done registered round-key stream; rd_idx/rd_rk/buf_valid round-key buffer
// read port, present only when SM4_RK_BUFFER_EN is defined (otherwise rd_rk and buf_valid are 0).

module sm4_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };
    assign dout = SBOX[din];
endmodule

module sm4_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] mkey,
    output logic [4:0]   ck_num,
    input  logic [31:0]  ck_in,
    output logic         rk_valid,
    output logic [4:0]   rk_idx,
    output logic [31:0]  rk,
    output logic         done,
    input  logic [4:0]   rd_idx,
    output logic [31:0]  rd_rk,
    output logic         buf_valid
);
    typedef enum logic {IDLE, ROUND} state_t;

    state_t      state_q, state_d;
    logic [31:0] k_q [4];
    logic [31:0] k_d [4];
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rk_q, rk_d;
    logic [4:0]  rk_idx_q, rk_idx_d;
    logic        rk_valid_q, rk_valid_d;
    logic        done_q, done_d;
    logic [31:0] x, b, rk_new;

    assign x = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_in;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sbox
            sm4_sbox u_sbox (.din(x[8*i +: 8]), .dout(b[8*i +: 8]));
        end
    endgenerate

    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    assign rk_new = k_q[0] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

    assign key_ready = (state_q == IDLE);
    assign ck_num    = (state_q == ROUND) ? cnt_q : 5'd0;
    assign rk        = rk_q;
    assign rk_idx    = rk_idx_q;
    assign rk_valid  = rk_valid_q;
    assign done      = done_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        rk_d       = rk_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = 1'b0;
        done_d     = 1'b0;
        if (state_q == IDLE) begin
            if (key_valid) begin
                k_d[0]  = mkey[127:96] ^ 32'hA3B1BAC6;
                k_d[1]  = mkey[95:64]  ^ 32'h56AA3350;
                k_d[2]  = mkey[63:32]  ^ 32'h677D9197;
                k_d[3]  = mkey[31:0]   ^ 32'hB27022DC;
                cnt_d   = 5'd0;
                state_d = ROUND;
            end
        end else begin
            k_d[0]     = k_q[1];
            k_d[1]     = k_q[2];
            k_d[2]     = k_q[3];
            k_d[3]     = rk_new;
            rk_d       = rk_new;
            rk_idx_d   = cnt_q;
            rk_valid_d = 1'b1;
            cnt_d      = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '{default: '0};
            cnt_q      <= '0;
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            rk_q       <= rk_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
        end
    end

`ifdef SM4_RK_BUFFER_EN
    logic [31:0] buf_q [32];
    logic [31:0] buf_d [32];
    logic        buf_valid_q, buf_valid_d;

    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        if (state_q == ROUND) buf_d[cnt_q] = rk_new;
        if (done_d) buf_valid_d = 1'b1;
        else if (key_valid && key_ready) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '{default: '0};
            buf_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign rd_rk     = buf_q[rd_idx];
    assign buf_valid = buf_valid_q;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_rk         = 32'd0;
    assign buf_valid     = 1'b0;
`endif
endmodule

// File: tb/tb_sm4_key_expand.sv
module tb_sm4_key_expand;
    typedef logic [31:0] sched_t [32];

    localparam logic [127:0] STD = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [7:0] SB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] mkey = '0;
    logic [4:0]   ck_num;
    logic [31:0]  ck_in;
    logic         rk_valid;
    logic [4:0]   rk_idx;
    logic [31:0]  rk;
    logic         done;
    logic [4:0]   rd_idx = '0;
    logic [31:0]  rd_rk;
    logic         buf_valid;

    int n_tests = 0;
    int n_fail = 0;
    bit rd_rand = 1'b1;

    sm4_key_expand dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .mkey(mkey),
        .ck_num(ck_num), .ck_in(ck_in), .rk_valid(rk_valid), .rk_idx(rk_idx), .rk(rk),
        .done(done), .rd_idx(rd_idx), .rd_rk(rd_rk), .buf_valid(buf_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // CK byte j of word i is (4i+j)*7 mod 256.
    function automatic logic [31:0] ck_word(input int i);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) w = (w << 8) | 32'(((4 * i + j) * 7) % 256);
        return w;
    endfunction

    function automatic sched_t expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] x, t;
        sched_t r;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i);
            t = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
            k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
            r[i] = k[i+4];
        end
        return r;
    endfunction

    always_comb ck_in = ck_word(int'(ck_num));

    // Reference: on accept the whole schedule is computed up front and then replayed one word per cycle.
    logic        m_idle = 1'b1;
    logic [4:0]  m_cnt = '0;
    sched_t      m_sched;
    logic [31:0] m_rk = '0;
    logic [4:0]  m_idx = '0;
    logic        m_rkv = 1'b0;
    logic        m_done = 1'b0;
    logic        m_bufv = 1'b0;
    logic [31:0] m_buf [32] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1; m_cnt <= '0; m_rk <= '0; m_idx <= '0;
            m_rkv <= 1'b0; m_done <= 1'b0; m_bufv <= 1'b0; m_buf <= '{default: '0};
        end else begin
            m_rkv  <= 1'b0;
            m_done <= 1'b0;
            if (m_idle) begin
                if (key_valid) begin
                    m_sched <= expand(mkey);
                    m_cnt   <= '0;
                    m_idle  <= 1'b0;
                    m_bufv  <= 1'b0;
                end
            end else begin
                m_rk         <= m_sched[m_cnt];
                m_idx        <= m_cnt;
                m_rkv        <= 1'b1;
                m_buf[m_cnt] <= m_sched[m_cnt];
                m_cnt        <= m_cnt + 5'd1;
                if (m_cnt == 5'd31) begin
                    m_done <= 1'b1;
                    m_idle <= 1'b1;
                    m_bufv <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("key_ready", 32'(key_ready), 32'(m_idle));
            chk("ck_num", 32'(ck_num), m_idle ? 32'd0 : 32'(m_cnt));
            chk("rk_valid", 32'(rk_valid), 32'(m_rkv));
            chk("rk_idx", 32'(rk_idx), 32'(m_idx));
            chk("rk", rk, m_rk);
            chk("done", 32'(done), 32'(m_done));
`ifdef SM4_RK_BUFFER_EN
            chk("buf_valid", 32'(buf_valid), 32'(m_bufv));
            chk("rd_rk", rd_rk, m_buf[rd_idx]);
`else
            chk("buf_valid_off", 32'(buf_valid), 32'd0);
            chk("rd_rk_off", rd_rk, 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (rd_rand) rd_idx = 5'($urandom_range(0, 31));
    endtask

    task automatic accept(input logic [127:0] k);
        key_valid = 1'b1;
        mkey = k;
        step();
        key_valid = 1'b0;
        mkey = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done();
        for (int n = 0; n < 40 && !done; n++) step();
        chk("done_within_bound", 32'(done), 32'd1);
    endtask

    sched_t s;
    logic [127:0] kc;

    initial begin
        repeat (3) step();
        chk("rst_key_ready", 32'(key_ready), 32'd1);
        chk("rst_rk_valid", 32'(rk_valid), 32'd0);
        chk("rst_ck_num", 32'(ck_num), 32'd0);
        s = expand(STD);
        chk("model_rk0", s[0], 32'hF12186F9);
        chk("model_rk1", s[1], 32'h41662B61);
        chk("model_rk31", s[31], 32'h9124A012);
        rst_n = 1'b1;
        step();

        // Standard vector with a stray key_valid pulse around E10.
        accept(STD);
        chk("busy_key_ready", 32'(key_ready), 32'd0);
        for (int e = 1; e <= 40 && !done; e++) begin
            if (e == 10) key_valid = 1'b1;
            step();
            if (e == 10) key_valid = 1'b0;
            if (rk_valid && rk_idx == 5'd0) chk("std_rk0", rk, 32'hF12186F9);
            if (rk_valid && rk_idx == 5'd1) chk("std_rk1", rk, 32'h41662B61);
            if (rk_valid && rk_idx == 5'd31) chk("std_rk31", rk, 32'h9124A012);
        end
        chk("std_done", 32'(done), 32'd1);
        chk("std_done_idx", 32'(rk_idx), 32'd31);
        chk("std_ready_in_done", 32'(key_ready), 32'd1);

`ifdef SM4_RK_BUFFER_EN
        rd_rand = 1'b0;
        rd_idx = 5'd31;
        #1 chk("buf_rd31", rd_rk, 32'h9124A012);
        rd_idx = 5'd0;
        #1 chk("buf_rd0", rd_rk, 32'hF12186F9);
        chk("buf_valid_set", 32'(buf_valid), 32'd1);
        rd_rand = 1'b1;
`endif
        step();

        // New key drops buf_valid; a key held during the run is accepted in the done cycle.
        accept({$urandom, $urandom, $urandom, $urandom});
`ifdef SM4_RK_BUFFER_EN
        chk("buf_valid_clr", 32'(buf_valid), 32'd0);
`endif
        for (int n = 0; n < 40 && !(rk_valid && rk_idx == 5'd20); n++) step();
        kc = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        mkey = kc;
        wait_done();
        step();
        key_valid = 1'b0;
        chk("b2b_gap_valid", 32'(rk_valid), 32'd0);
        chk("b2b_busy", 32'(key_ready), 32'd0);
        step();
        s = expand(kc);
        chk("b2b_valid", 32'(rk_valid), 32'd1);
        chk("b2b_idx0", 32'(rk_idx), 32'd0);
        chk("b2b_rk0", rk, s[0]);
        wait_done();

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) step();
            accept({$urandom, $urandom, $urandom, $urandom});
            wait_done();
        end
        step();

        // Reset in the middle of an expansion.
        accept(STD);
        for (int n = 0; n < 40 && !(rk_valid && rk_idx == 5'd12); n++) step();
        chk("mid_idx12_seen", 32'(rk_idx), 32'd12);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rk_valid", 32'(rk_valid), 32'd0);
        chk("mid_rst_rk", rk, 32'd0);
        chk("mid_rst_rk_idx", 32'(rk_idx), 32'd0);
        chk("mid_rst_ready", 32'(key_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ck_num", 32'(ck_num), 32'd0);
        chk("mid_rst_buf_valid", 32'(buf_valid), 32'd0);
        repeat (2) step();
        chk("held_rst_rk_valid", 32'(rk_valid), 32'd0);
        rst_n = 1'b1;
        step();
        accept(STD);
        step();
        chk("rerun_idx0", 32'(rk_idx), 32'd0);
        chk("rerun_rk0", rk, 32'hF12186F9);
        wait_done();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sm4_key_expand.md
# sm4_key_expand

Iterative SM4 key-schedule engine. It accepts a 128-bit master key and produces the 32 round keys rk0..rk31, one per clock. Each round it drives the round index to the CK constant lookup and consumes the returned CK word. The block sits between the key input interface and the SM4 round datapath, which consumes the round-key stream (or, when compiled in, the round-key buffer).

## Interface
Parameters:
- none; the SM4 algorithm fixes all widths.

Ports:
- clk  in  1  — single clock; all state changes on the rising edge.
- rst_n  in  1  — asynchronous active-low reset.
- key_valid  in  1  — master key presented.
- key_ready  out  1  — block idle; a key is accepted on a cycle where key_valid and key_ready are both 1.
- mkey  in  [0:127]  — master key; bit 0 is the MSB; MK0 = mkey[0:31] … MK3 = mkey[96:127].
- ck_num  out  [0:4]  — round index sent to the CK lookup.
- ck_in  in  [0:31]  — CK word for ck_num; combinational, same cycle.
- rk_valid  out  1  — registered; rk and rk_idx are valid.
- rk_idx  out  [0:4]  — registered index of rk.
- rk  out  [0:31]  — registered round key.
- done  out  1  — registered one-cycle pulse that accompanies rk_idx = 31.
- rd_idx  in  [0:4]  — buffer read index.
- rd_rk  out  [0:31]  — buffer read data; combinational.
- buf_valid  out  1  — buffer holds a complete schedule.

## Operation
- S-box: τ uses four instances of the team's combinational `sm4_sbox` (8-bit in, 8-bit out), one per byte.
- FK constants: FK0 = A3B1BAC6, FK1 = 56AA3350, FK2 = 677D9197, FK3 = B27022DC.
- States: IDLE and ROUND; reset state is IDLE.
- key_ready = (state == IDLE).
- IDLE, on accept:
  - load K0..K3 = MKj ^ FKj into four 32-bit registers;
  - clear cnt to 0;
  - go to ROUND.
- ROUND, every cycle:
  - ck_num = cnt;
  - X = K1^K2^K3^ck_in;
  - new = K0 ^ L'(τ(X)), where L'(B) = B ^ (B<<<13) ^ (B<<<23);
  - shift K0←K1, K1←K2, K2←K3, K3←new;
  - register rk ← new, rk_idx ← cnt, rk_valid ← 1;
  - cnt increments.
- Leaving ROUND: when cnt = 31, the cycle registers done ← 1 with the last key, and the state returns to IDLE.
- ck_num = 0 in IDLE.
- Wrap-around: cnt is 5 bits and is never used past 31. Leaving ROUND is decided by cnt == 31, not by overflow.
- Inputs ignored while key_ready = 0: key_valid and mkey. A master key held across the busy window is accepted only once key_ready returns to 1.
- Reset values (also on rst_n asserted mid-expansion): state IDLE, key_ready 1, K0..K3 0, cnt 0, rk 0, rk_idx 0, rk_valid 0, done 0, ck_num 0, buf_valid 0, and the buffer is cleared. After reset the partial schedule is discarded and no further rk_valid is emitted.

## Timing
- Key accepted at edge E0 (key_valid and key_ready both high before E0).
- Cycles E0..E31: state ROUND, cnt 0..31, key_ready 0.
- rk_valid is high from E1 to E32 with rk_idx 0..31. The output is fixed-rate with no backpressure; the consumer must take every word.
- done is high for the single cycle after E32, together with rk_idx = 31.
- key_ready returns to 1 in that same cycle, so back-to-back keys are accepted with no gap cycle.
- Total latency: 33 cycles from accept edge to done; throughput is one key per 33 cycles.

## Configuration
- SM4_RK_BUFFER_EN defined:
  - 32×32 register buffer; each ROUND cycle writes new to buf[cnt];
  - rd_rk = buf[rd_idx], combinational, giving random access for decryption's reverse order;
  - buf_valid is set with done and cleared on the next key accept;
  - the buffer is cleared on reset.
- SM4_RK_BUFFER_EN undefined: no buffer storage; rd_rk is constant 0, buf_valid is constant 0, and rd_idx is ignored.
- Streaming outputs behave identically in both builds.

## Test plan
- Standard vector: mkey = 0123456789ABCDEFFEDCBA9876543210 → rk0 = F12186F9, rk1 = 41662B61, rk31 = 9124A012. rk_idx counts 0..31 contiguously and done coincides with rk31.
- Handshake and timing: accept at E0 → rk_valid from E1 to E32; ck_num = 0..31 in cycles E0..E31; key_ready low from E0 to E31. key_valid pulsed at E10 → ignored, with no restart and an identical stream.
- Back-to-back: second key held with key_valid = 1 → accepted in the done cycle. The second stream follows after exactly one rk_valid-low cycle, and rk0 of the second key is correct.
- Reset mid-operation: rst_n low after rk_idx = 12 → outputs immediately at reset values, no further rk_valid. Re-accepting the standard vector then yields correct rk0 = F12186F9.
- Buffer build (SM4_RK_BUFFER_EN): after the standard vector, rd_idx = 31 → rd_rk = 9124A012 and rd_idx = 0 → F12186F9, with buf_valid = 1. A new accept drops buf_valid to 0 immediately.
- Buffer compiled out: rd_idx swept 0..31 → rd_rk = 0 and buf_valid = 0 throughout; the stream is unchanged.
